// File: rtl/rgb_pwm_driver.sv
// RGB PWM LED driver: double-buffered colour, frame-aligned updates,
// global 2-bit dimming shift.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  input  logic [1:0]  dim,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_start,
  output logic        update_pending
);

  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt;
  logic [23:0]   staged;
  logic [23:0]   active;
  logic [1:0]    act_dim;

  logic          tick;
  logic          wrap;
  logic [7:0]    pwm_nxt;
  logic [23:0]   act_nxt;
  logic [1:0]    dim_nxt;
  logic [7:0]    eff_r;
  logic [7:0]    eff_g;
  logic [7:0]    eff_b;

  always_comb begin
    tick    = (pre_cnt == PMAX);
    wrap    = tick && (pwm_cnt == 8'hFF);
    pwm_nxt = pwm_cnt;
    if (tick)
      pwm_nxt = pwm_cnt + 8'd1;
    act_nxt = active;
    dim_nxt = act_dim;
    if (wrap) begin
      dim_nxt = dim;
      priority case (1'b1)
        rgb_valid:      act_nxt = rgb_in;
        update_pending: act_nxt = staged;
        default:        act_nxt = active;
      endcase
    end
    eff_r = act_nxt[23:16] >> dim_nxt;
    eff_g = act_nxt[15:8]  >> dim_nxt;
    eff_b = act_nxt[7:0]   >> dim_nxt;
  end

  // LEDs compare next-state count/duty so they line up with frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt        <= '0;
      pwm_cnt        <= '0;
      staged         <= '0;
      active         <= '0;
      act_dim        <= '0;
      update_pending <= 1'b0;
      frame_start    <= 1'b0;
      led_r          <= 1'b0;
      led_g          <= 1'b0;
      led_b          <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      pwm_cnt <= pwm_nxt;
      if (rgb_valid)
        staged <= rgb_in;
      if (wrap)
        update_pending <= 1'b0;
      else if (rgb_valid)
        update_pending <= 1'b1;
      active      <= act_nxt;
      act_dim     <= dim_nxt;
      frame_start <= wrap;
      led_r       <= (pwm_nxt < eff_r);
      led_g       <= (pwm_nxt < eff_g);
      led_b       <= (pwm_nxt < eff_b);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three prescale variants against a
// frame-arithmetic reference model plus frame high-time vectors.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        rgb_valid = 1'b0;
  logic [1:0]  dim = '0;
  logic [2:0]  lr, lg, lb, fs, up;

  int vec = 0;
  int miss = 0;

  localparam int PS [3] = '{1, 2, 4};

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .rgb_valid(rgb_valid), .dim(dim),
    .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]),
    .frame_start(fs[0]), .update_pending(up[0]));

  rgb_pwm_driver #(.PRESCALE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .rgb_valid(rgb_valid), .dim(dim),
    .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]),
    .frame_start(fs[1]), .update_pending(up[1]));

  rgb_pwm_driver #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .rgb_valid(rgb_valid), .dim(dim),
    .led_r(lr[2]), .led_g(lg[2]), .led_b(lb[2]),
    .frame_start(fs[2]), .update_pending(up[2]));

  // reference model: position in frame from cycles since release
  int          cyc [3] = '{0, 0, 0};
  logic [23:0] stg [3] = '{0, 0, 0};
  logic [23:0] act [3] = '{0, 0, 0};
  logic        pend [3] = '{0, 0, 0};
  int          ad [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        cyc[k] = 0; stg[k] = 0; act[k] = 0;
        pend[k] = 0; ad[k] = 0;
      end else begin
        if (cyc[k] % (256 * PS[k]) == 256 * PS[k] - 1) begin
          if (rgb_valid) act[k] = rgb_in;
          else if (pend[k]) act[k] = stg[k];
          ad[k] = int'(dim);
          pend[k] = 0;
        end else if (rgb_valid) begin
          pend[k] = 1;
        end
        if (rgb_valid) stg[k] = rgb_in;
        cyc[k]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int t, pw;
      logic [4:0] ex, got;
      t  = cyc[k] % (256 * PS[k]);
      pw = t / PS[k];
      ex[4] = pw < (int'(act[k][23:16]) / (1 << ad[k]));
      ex[3] = pw < (int'(act[k][15:8]) / (1 << ad[k]));
      ex[2] = pw < (int'(act[k][7:0]) / (1 << ad[k]));
      ex[1] = (cyc[k] > 0) && (t == 0);
      ex[0] = pend[k];
      got = {lr[k], lg[k], lb[k], fs[k], up[k]};
      vec++;
      if (got !== ex) begin
        miss++;
        $display("FAIL model dut%0d t=%0t got %b want %b",
                 k, $time, got, ex);
      end
    end
  end

  // per-frame LED high counts, segmented by frame_start
  int acc [3][3];
  int last [3][3];
  int nfr [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        nfr[k] = 0;
        for (int c = 0; c < 3; c++) begin
          acc[k][c] = 0; last[k][c] = 0;
        end
      end else begin
        if (fs[k]) begin
          nfr[k]++;
          for (int c = 0; c < 3; c++) begin
            last[k][c] = acc[k][c]; acc[k][c] = 0;
          end
        end
        acc[k][0] += int'(lr[k]);
        acc[k][1] += int'(lg[k]);
        acc[k][2] += int'(lb[k]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int got,
                     input int ex);
    vec++;
    if (got != ex) begin
      miss++;
      $display("FAIL %s got %0d want %0d", nm, got, ex);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rgb_valid = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [23:0] c);
    rgb_in = c;
    rgb_valid = 1'b1;
    step(1);
    rgb_valid = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int n);
    int i;
    for (i = 0; i < 20000; i++) begin
      if (nfr[k] >= n) break;
      step(1);
    end
    if (i == 20000) begin
      miss++;
      $display("FAIL timeout dut%0d frames %0d want %0d",
               k, nfr[k], n);
    end
  endtask

  task automatic chk_frame(input int er, input int eg,
                           input int eb);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("high_r dut%0d", k), last[k][0], er * PS[k]);
      chk($sformatf("high_g dut%0d", k), last[k][1], eg * PS[k]);
      chk($sformatf("high_b dut%0d", k), last[k][2], eb * PS[k]);
    end
  endtask

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  dm;
    int er, eg, eb;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{24'hFF8000, 2'd0, 255, 128, 0};
    tbl[1] = '{24'h404040, 2'd2, 16, 16, 16};
    tbl[2] = '{24'hFFFFFF, 2'd3, 31, 31, 31};
    tbl[3] = '{24'h000007, 2'd3, 0, 0, 0};
    tbl[4] = '{24'h0A0B0C, 2'd0, 10, 11, 12};
    tbl[5] = '{24'h123456, 2'd1, 9, 26, 43};

    do_reset();
    chk("reset pending", int'(up), 0);
    chk("reset leds", int'({lr, lg, lb}), 0);

    foreach (tbl[i]) begin
      dim = tbl[i].dm;
      do_reset();
      step(5);
      pulse(tbl[i].rgb);
      chk("pending after valid", int'(up), 7);
      wait_frames(2, 2);
      chk_frame(tbl[i].er, tbl[i].eg, tbl[i].eb);
    end

    // dim change mid-frame only applies at next boundary
    dim = 2'd2;
    do_reset();
    step(5);
    pulse(24'h404040);
    wait_frames(2, 2);
    chk("dim2 frame", last[2][0], 64);
    step(100);
    dim = 2'd0;
    wait_frames(2, 3);
    chk("dim held", last[2][1], 64);
    wait_frames(2, 4);
    chk("dim0 frame", last[2][2], 256);

    // last write within a frame wins
    do_reset();
    step(20);
    pulse(24'h010101);
    step(30);
    pulse(24'h0A0B0C);
    wait_frames(2, 2);
    chk_frame(10, 11, 12);

    // valid on the exact wrap edge of the PRESCALE=1 unit
    do_reset();
    step(10);
    pulse(24'h050000);
    step(244);
    rgb_in = 24'h200000;
    rgb_valid = 1'b1;
    step(1);
    rgb_valid = 1'b0;
    chk("bypass pending", int'(up[0]), 0);
    chk("bypass led_r", int'(lr[0]), 1);
    chk("bypass fs", int'(fs[0]), 1);
    wait_frames(0, 2);
    chk("bypass high_r", last[0][0], 32);
    wait_frames(0, 3);
    chk("bypass held", last[0][0], 32);

    // asynchronous reset mid-frame with LEDs lit
    do_reset();
    pulse(24'hFFFFFF);
    wait_frames(1, 2);
    step(20);
    chk("lit before reset", int'({lr[1], lg[1], lb[1]}), 7);
    rst_n = 1'b0;
    #2;
    chk("async reset outs",
        int'({lr, lg, lb, fs, up}), 0);
    step(2);
    rst_n = 1'b1;
    step(511);
    chk("no early frame", nfr[1], 0);
    step(1);
    chk("first frame at 512", nfr[1], 1);
    chk("dark first frame",
        last[1][0] + last[1][1] + last[1][2], 0);

    // random traffic checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      rgb_in = 24'($urandom);
      rgb_valid = ($urandom % 40) == 0;
      if ($urandom % 500 == 0) dim = 2'($urandom);
      if ($urandom % 3000 == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    rgb_valid = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream consumer of the RGB colour converter. It takes the 24-bit RGB word (R in [23:16], G in [15:8], B in [7:0]) plus a valid strobe, and drives three LED pins with 8-bit PWM.
- New colours are double-buffered. They take effect only at a PWM frame boundary, so no frame ever shows a partial-duty glitch.
- A 2-bit global dimming control scales all three duties.

Parameters:
- PRESCALE, 4: clk cycles per PWM tick; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rgb_in  input  24  colour word from the converter: R[23:16], G[15:8], B[7:0].
- rgb_valid  input  1  rgb_in is valid this cycle. Upstream asserts it one cycle after the converter enable, to match the BRAM read latency.
- dim  input  2  brightness shift: effective duty = duty >> dim.
- led_r  output  1  red PWM output.
- led_g  output  1  green PWM output.
- led_b  output  1  blue PWM output.
- frame_start  output  1  one-cycle pulse marking the first cycle of each PWM frame.
- update_pending  output  1  a staged colour is waiting for the next frame boundary.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-frame):
  - Prescaler counter, pwm_cnt, staged and active duty registers, active dim, and update_pending all go to 0.
  - led_r, led_g, led_b and frame_start go to 0.
  - Release is synchronous to the next clk edge.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pre_cnt == PRESCALE-1).
  - With PRESCALE=1, tick is high every cycle.
- PWM counter:
  - pwm_cnt is 8 bits and increments on tick; 255 wraps to 0.
  - Frame period = 256*PRESCALE clk cycles.
  - wrap = tick and (pwm_cnt == 255).
- Staging:
  - On any edge with rgb_valid=1, the staged register loads rgb_in and update_pending goes to 1.
  - Multiple valids within one frame: last write wins.
- Frame boundary (edge where wrap=1):
  - Active duties load the colour. If rgb_valid=1 on this same edge, rgb_in is loaded directly (bypass). Otherwise, if update_pending=1, the staged value is loaded.
  - If neither, active duties hold.
  - update_pending is cleared, including in the bypass case.
  - Active dim loads dim. dim changes between boundaries have no effect.
- frame_start:
  - Registered; high exactly in the cycle where pwm_cnt==0 and pre_cnt==0 after a wrap.
  - Not asserted at reset release. The first pulse occurs 256*PRESCALE cycles after reset release.
- Effective duty: eff_x = active_x >> active_dim, where active_x is the 8-bit active duty for that channel, giving a result in 0..255.
- Outputs:
  - Each LED is registered: led_x <= (pwm_cnt < eff_x), evaluated every cycle.
  - High time per frame = eff_x * PRESCALE cycles, starting at frame_start.
  - eff=0 means the LED is never high. eff=255 means high for 255/256 of the frame.
  - The LEDs are off until the first frame boundary after reset.
- Duty and dim registers do not change except at wrap, so any frame's output is fully determined by the values latched at its start.

Test Plan:
1. PRESCALE=1; rst_n low 3 cycles, then high; rgb_in=24'hFF8000 with rgb_valid one cycle.
   - update_pending=1 until the first wrap at cycle 256, then 0.
   - In the next frame, led_r high 255 cycles, led_g high 128 cycles, led_b never high.
   - frame_start pulses every 256 cycles.
2. PRESCALE=4; active colour 24'h404040, dim=2.
   - Each LED is high 16*4=64 cycles per 1024-cycle frame.
   - Changing dim to 0 mid-frame has no effect until the next boundary; the following frame gives 256 high cycles.
3. PRESCALE=1; mid-frame valids 24'h010101, then 24'h0A0B0C.
   - Only 0A/0B/0C take effect; high times are 10/11/12 cycles in the next frame.
4. PRESCALE=1; rgb_valid asserted on the exact wrap edge with 24'h200000.
   - New frame: led_r high 32 cycles immediately (bypass); update_pending reads 0 afterwards.
5. PRESCALE=2; reset asserted mid-frame while LEDs are high.
   - All outputs drop to 0 immediately, without waiting for clk.
   - After release, the LEDs stay 0 for a full 512-cycle frame; no frame_start appears until cycle 512.
6. Colour 24'hFFFFFF, dim=3, then 24'h000007 with dim=3.
   - First: eff=31, 31*PRESCALE high cycles.
   - Second: eff=0, all LEDs stay low.
